// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
//
// Miss-service and write-through controller sitting between NCH single-port
// caches and a pipelined main memory. Stores are sent straight to memory.
// A miss is served by reading a whole block, one word per cycle with no gaps,
// and steering each returning word into the granted cache's data array. The
// tag array is written together with the last word.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   miss, miss_addr   per-channel miss request and byte address (NCH*AWIDTH packed)
//   wr_req/addr/data  store request; wr_ack pulses when the store goes to memory
//   mem_*             memory strobe/write/address/wdata out, rdata/data_valid in
//   fill_data_wen     one-hot data-array write enable of the granted channel
//   fill_tag_wen      one-hot tag-array write enable, on the last word of a block
//   fill_addr/data    address and data of the word being written into the cache
//   stall             per-channel stall (missing, or currently being filled)
//   busy              controller is not idle
module cache_fill_arbiter #(
    parameter int NCH     = 2,
    parameter int AWIDTH  = 16,
    parameter int DWIDTH  = 16,
    parameter int WORDS   = 8,
    parameter int RR_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          miss,
    input  logic [NCH*AWIDTH-1:0]   miss_addr,
    input  logic                    wr_req,
    input  logic [AWIDTH-1:0]       wr_addr,
    input  logic [DWIDTH-1:0]       wr_data,
    output logic                    wr_ack,
    output logic                    mem_enable,
    output logic                    mem_wr,
    output logic [AWIDTH-1:0]       mem_addr,
    output logic [DWIDTH-1:0]       mem_wdata,
    input  logic [DWIDTH-1:0]       mem_rdata,
    input  logic                    mem_data_valid,
    output logic [NCH-1:0]          fill_data_wen,
    output logic [NCH-1:0]          fill_tag_wen,
    output logic [AWIDTH-1:0]       fill_addr,
    output logic [DWIDTH-1:0]       fill_data,
    output logic [NCH-1:0]          stall,
    output logic                    busy
);
    localparam int GW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW       = $clog2(WORDS) + 1;
    localparam int STEP     = DWIDTH / 8;
    localparam int OFF_BITS = $clog2(WORDS * STEP);

    localparam logic [AWIDTH-1:0] BLOCK_MASK = {AWIDTH{1'b1}} << OFF_BITS;
    localparam logic [AWIDTH-1:0] STEP_A     = AWIDTH'(STEP);
    localparam logic [CW-1:0]     WORDS_C    = CW'(WORDS);
    localparam logic [CW-1:0]     LAST_C     = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FILL
    } state_t;

    state_t              state_reg;
    logic [GW-1:0]       grant_reg;
    logic [GW-1:0]       rr_ptr_reg;
    logic [AWIDTH-1:0]   base_reg;
    logic [AWIDTH-1:0]   wr_addr_reg;
    logic [DWIDTH-1:0]   wr_data_reg;
    logic [CW-1:0]       issue_cnt_reg;
    logic [CW-1:0]       rcv_cnt_reg;

    logic [GW-1:0]       pick;
    logic [AWIDTH-1:0]   pick_addr;
    logic [2*NCH-1:0]    miss_dbl;
    logic [NCH-1:0]      miss_rot;
    logic                issuing;
    logic                filling;

    // Round-robin search: rotate the request vector so rr_ptr lands at bit 0,
    // then take the lowest set bit and map it back to a channel index.
    assign miss_dbl = {miss, miss};
    assign miss_rot = (RR_MODE != 0) ? miss_dbl[int'(rr_ptr_reg) +: NCH] : miss;

    // Scanning from the top down leaves the lowest set bit as the winner.
    always_comb begin
        pick = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (miss_rot[i]) begin
                pick = (RR_MODE != 0) ? GW'((int'(rr_ptr_reg) + i) % NCH) : GW'(i);
            end
        end
    end

    assign pick_addr = miss_addr[int'(pick)*AWIDTH +: AWIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            base_reg      <= '0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            issue_cnt_reg <= '0;
            rcv_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Stores win so that a later fill reads the updated word.
                    if (wr_req) begin
                        wr_addr_reg <= wr_addr;
                        wr_data_reg <= wr_data;
                        state_reg   <= ST_WRITE;
                    end else if (|miss) begin
                        grant_reg     <= pick;
                        rr_ptr_reg    <= GW'((int'(pick) + 1) % NCH);
                        base_reg      <= pick_addr & BLOCK_MASK;
                        issue_cnt_reg <= '0;
                        rcv_cnt_reg   <= '0;
                        state_reg     <= ST_FILL;
                    end
                end
                ST_WRITE: begin
                    state_reg <= ST_IDLE;
                end
                ST_FILL: begin
                    // Issue and receive run independently; the block is done
                    // when the last word comes back.
                    if (issue_cnt_reg < WORDS_C) begin
                        issue_cnt_reg <= issue_cnt_reg + CW'(1);
                    end
                    if (mem_data_valid) begin
                        rcv_cnt_reg <= rcv_cnt_reg + CW'(1);
                        if (rcv_cnt_reg == LAST_C) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign issuing    = (state_reg == ST_FILL) && (issue_cnt_reg < WORDS_C);
    assign filling    = (state_reg == ST_FILL) && mem_data_valid;

    assign busy       = (state_reg != ST_IDLE);
    assign wr_ack     = (state_reg == ST_WRITE);
    assign mem_wr     = wr_ack;
    assign mem_enable = wr_ack | issuing;
    assign mem_addr   = wr_ack  ? wr_addr_reg :
                        issuing ? base_reg + AWIDTH'(issue_cnt_reg) * STEP_A : '0;
    assign mem_wdata  = wr_ack ? wr_data_reg : '0;
    assign fill_addr  = filling ? base_reg + AWIDTH'(rcv_cnt_reg) * STEP_A : '0;
    assign fill_data  = filling ? mem_rdata : '0;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic granted;
            assign granted           = (grant_reg == GW'(gi));
            assign fill_data_wen[gi] = filling && granted;
            assign fill_tag_wen[gi]  = filling && granted && (rcv_cnt_reg == LAST_C);
            assign stall[gi]         = miss[gi] | ((state_reg == ST_FILL) && granted);
        end
    endgenerate

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: a fixed-priority instance and a round-robin
// instance, each with a latency-4 memory model. Stimulus pushes expected
// memory accesses and fill writes into queues; monitors pop and compare.
module tb_cache_fill_arbiter;
    localparam int NCH   = 2;
    localparam int WORDS = 8;
    localparam int L     = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // fixed-priority instance
    logic [1:0]  miss;
    logic [31:0] miss_addr;
    logic        wr_req;
    logic [15:0] wr_addr, wr_data;
    logic        wr_ack, mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_data_valid = 1'b0;
    logic [1:0]  fill_data_wen, fill_tag_wen, stall;
    logic [15:0] fill_addr, fill_data;
    logic        busy;

    // round-robin instance
    logic [1:0]  miss_rr;
    logic [31:0] miss_addr_rr;
    logic        wr_req_rr;
    logic [15:0] wr_addr_rr, wr_data_rr;
    logic        wr_ack_rr, mem_enable_rr, mem_wr_rr;
    logic [15:0] mem_addr_rr, mem_wdata_rr;
    logic [15:0] mem_rdata_rr = 16'h0;
    logic        mem_data_valid_rr = 1'b0;
    logic [1:0]  fill_data_wen_rr, fill_tag_wen_rr, stall_rr;
    logic [15:0] fill_addr_rr, fill_data_rr;
    logic        busy_rr;

    cache_fill_arbiter #(.NCH(NCH), .AWIDTH(16), .DWIDTH(16), .WORDS(WORDS), .RR_MODE(0)) dut (
        .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .fill_data_wen(fill_data_wen), .fill_tag_wen(fill_tag_wen),
        .fill_addr(fill_addr), .fill_data(fill_data), .stall(stall), .busy(busy)
    );

    cache_fill_arbiter #(.NCH(NCH), .AWIDTH(16), .DWIDTH(16), .WORDS(WORDS), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .miss(miss_rr), .miss_addr(miss_addr_rr),
        .wr_req(wr_req_rr), .wr_addr(wr_addr_rr), .wr_data(wr_data_rr), .wr_ack(wr_ack_rr),
        .mem_enable(mem_enable_rr), .mem_wr(mem_wr_rr), .mem_addr(mem_addr_rr), .mem_wdata(mem_wdata_rr),
        .mem_rdata(mem_rdata_rr), .mem_data_valid(mem_data_valid_rr),
        .fill_data_wen(fill_data_wen_rr), .fill_tag_wen(fill_tag_wen_rr),
        .fill_addr(fill_addr_rr), .fill_data(fill_data_rr), .stall(stall_rr), .busy(busy_rr)
    );

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5AC3;
    endfunction

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        logic [1:0]  wen;
        logic [1:0]  tag;
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } fill_exp_t;

    mem_exp_t  q_mem[$];
    fill_exp_t q_fill[$];
    logic [1:0] q_rr[$];

    int checks = 0, failures = 0;
    int fill_seen = 0, tag_seen = 0, ack_seen = 0, rr_tags = 0;

    // memory models: a read captured in one cycle returns L cycles later
    bit          pv[L], rv[L];
    logic [15:0] pa[L], ra[L];
    always @(negedge clk) begin
        mem_data_valid    = pv[L-1];
        mem_rdata         = pv[L-1] ? mdata(pa[L-1]) : 16'h0;
        mem_data_valid_rr = rv[L-1];
        mem_rdata_rr      = rv[L-1] ? mdata(ra[L-1]) : 16'h0;
        for (int i = L - 1; i > 0; i--) begin
            pv[i] = pv[i-1]; pa[i] = pa[i-1];
            rv[i] = rv[i-1]; ra[i] = ra[i-1];
        end
        pv[0] = mem_enable && !mem_wr;       pa[0] = mem_addr;
        rv[0] = mem_enable_rr && !mem_wr_rr; ra[0] = mem_addr_rr;
    end

    // monitor for the fixed-priority instance
    mem_exp_t  me;
    fill_exp_t fe;
    always begin
        @(negedge clk); #2;
        if (mem_enable) begin
            checks++;
            if (q_mem.size() == 0) begin
                failures++;
                $display("FAIL mem_unexpected wr=%0b addr=%h cyc=%0d", mem_wr, mem_addr, cyc);
            end else begin
                me = q_mem.pop_front();
                if (mem_wr !== me.wr || wr_ack !== me.wr || mem_addr !== me.addr ||
                    (me.wr && mem_wdata !== me.data) || cyc != me.cyc) begin
                    failures++;
                    $display("FAIL mem_access got wr=%0b ack=%0b addr=%h wdata=%h cyc=%0d required wr=%0b addr=%h wdata=%h cyc=%0d",
                             mem_wr, wr_ack, mem_addr, mem_wdata, cyc, me.wr, me.addr, me.data, me.cyc);
                end else begin
                    $display("mem %s addr=%h wdata=%h cyc=%0d", me.wr ? "wr" : "rd", mem_addr, mem_wdata, cyc);
                end
            end
        end else if (wr_ack) begin
            checks++;
            failures++;
            $display("FAIL wr_ack_without_enable cyc=%0d", cyc);
        end
        if (wr_ack) ack_seen++;
        if (|fill_data_wen || |fill_tag_wen) begin
            checks++;
            if (q_fill.size() == 0) begin
                failures++;
                $display("FAIL fill_unexpected wen=%b tag=%b addr=%h cyc=%0d", fill_data_wen, fill_tag_wen, fill_addr, cyc);
            end else begin
                fe = q_fill.pop_front();
                if (fill_data_wen !== fe.wen || fill_tag_wen !== fe.tag || fill_addr !== fe.addr ||
                    fill_data !== fe.data || cyc != fe.cyc) begin
                    failures++;
                    $display("FAIL fill_write got wen=%b tag=%b addr=%h data=%h cyc=%0d required wen=%b tag=%b addr=%h data=%h cyc=%0d",
                             fill_data_wen, fill_tag_wen, fill_addr, fill_data, cyc, fe.wen, fe.tag, fe.addr, fe.data, fe.cyc);
                end else begin
                    $display("fill wen=%b tag=%b addr=%h data=%h cyc=%0d", fill_data_wen, fill_tag_wen, fill_addr, fill_data, cyc);
                end
            end
            fill_seen++;
            if (|fill_tag_wen) tag_seen++;
        end
    end

    // monitor for the round-robin instance: grant order via tag writes
    logic [1:0] rr_exp;
    always begin
        @(negedge clk); #2;
        if (|fill_tag_wen_rr) begin
            checks++;
            if (q_rr.size() == 0) begin
                failures++;
                $display("FAIL rr_unexpected tag=%b cyc=%0d", fill_tag_wen_rr, cyc);
            end else begin
                rr_exp = q_rr.pop_front();
                if (fill_tag_wen_rr !== rr_exp) begin
                    failures++;
                    $display("FAIL rr_grant got=%b required=%b cyc=%0d", fill_tag_wen_rr, rr_exp, cyc);
                end else begin
                    $display("rr grant done tag=%b cyc=%0d", fill_tag_wen_rr, cyc);
                end
            end
            rr_tags++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end else begin
            $display("check %s = %h", name, got);
        end
    endtask

    // Expected reads (one per cycle from cycle k) and fill writes (L later).
    task automatic push_fill(input int ch, input logic [15:0] base, input int k,
                             input int nr, input int nf);
        logic [15:0] a;
        for (int i = 0; i < nr; i++) begin
            a = base + 16'(i * 2);
            q_mem.push_back('{1'b0, a, 16'h0, k + i});
        end
        for (int i = 0; i < nf; i++) begin
            a = base + 16'(i * 2);
            q_fill.push_back('{2'(1 << ch), (i == WORDS - 1) ? 2'(1 << ch) : 2'b00, a, mdata(a), k + i + L});
        end
    endtask

    function automatic int get_cnt(input int sel);
        case (sel)
            0:       return tag_seen;
            1:       return fill_seen;
            2:       return ack_seen;
            default: return rr_tags;
        endcase
    endfunction

    task automatic wait_cnt(input string name, input int sel, input int target);
        int n;
        n = 0;
        while (get_cnt(sel) < target && n < 400) begin
            @(negedge clk); #3;
            n++;
        end
        checks++;
        if (get_cnt(sel) < target) begin
            failures++;
            $display("FAIL %s timeout count=%0d need=%0d", name, get_cnt(sel), target);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, f0, a0;
        miss = 2'b00; miss_addr = 32'h0; wr_req = 1'b0; wr_addr = 16'h0; wr_data = 16'h0;
        miss_rr = 2'b00; miss_addr_rr = 32'h0; wr_req_rr = 1'b0; wr_addr_rr = 16'h0; wr_data_rr = 16'h0;
        rst = 1'b0;

        // reset state
        #1;
        check("reset_ctrl", {26'h0, wr_ack, mem_enable, mem_wr, busy, fill_data_wen}, 32'h0);
        check("reset_tag_wen", {30'h0, fill_tag_wen}, 32'h0);
        check("reset_mem_bus", {mem_addr, mem_wdata}, 32'h0);
        check("reset_fill_bus", {fill_addr, fill_data}, 32'h0);
        miss = 2'b10;
        #1;
        check("reset_stall_follows_miss", {30'h0, stall}, 32'h2);
        miss = 2'b00;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // single D-cache miss
        @(negedge clk);
        miss_addr[15:0] = 16'h1236; miss = 2'b01;
        @(posedge clk); #1; k = cyc;
        push_fill(0, 16'h1230, k, WORDS, WORDS);
        wait_cnt("d_fill_tag", 0, tag_seen + 1);
        miss = 2'b00;
        @(posedge clk); #2;
        check("d_stall_after", {30'h0, stall}, 32'h0);
        check("d_busy_after", {31'h0, busy}, 32'h0);

        // simultaneous D and I miss, fixed priority
        @(negedge clk);
        miss_addr = {16'h0A1E, 16'h0104}; miss = 2'b11;
        @(posedge clk); #1; k = cyc;
        push_fill(0, 16'h0100, k, WORDS, WORDS);
        push_fill(1, 16'h0A10, k + WORDS + L + 1, WORDS, WORDS);
        wait_cnt("fix_ch0_tag", 0, tag_seen + 1);
        check("fix_stall1_during_ch0", {31'h0, stall[1]}, 32'h1);
        miss[0] = 1'b0;
        @(posedge clk); #2;
        check("fix_stall_between", {30'h0, stall}, 32'h2);
        @(posedge clk); @(posedge clk); #2;
        check("fix_stall_ch1_fill", {30'h0, stall}, 32'h2);
        wait_cnt("fix_ch1_tag", 0, tag_seen + 1);
        miss = 2'b00;

        // store in the same cycle as an I-cache miss
        @(negedge clk);
        wr_addr = 16'h0040; wr_data = 16'hBEEF; wr_req = 1'b1;
        miss_addr[31:16] = 16'h0A26; miss = 2'b10;
        @(posedge clk); #1; k = cyc;
        q_mem.push_back('{1'b1, 16'h0040, 16'hBEEF, k});
        push_fill(1, 16'h0A20, k + 2, WORDS, WORDS);
        @(negedge clk);
        wr_req = 1'b0;
        wait_cnt("store_then_fill_tag", 0, tag_seen + 1);
        miss = 2'b00;

        // store raised mid-fill waits for the fill to finish
        @(negedge clk);
        miss_addr[15:0] = 16'h2008; miss = 2'b01;
        @(posedge clk); #1; k = cyc;
        push_fill(0, 16'h2000, k, WORDS, WORDS);
        q_mem.push_back('{1'b1, 16'h0050, 16'h1234, k + WORDS + L + 1});
        a0 = ack_seen;
        repeat (3) @(negedge clk);
        wr_addr = 16'h0050; wr_data = 16'h1234; wr_req = 1'b1;
        wait_cnt("midfill_tag", 0, tag_seen + 1);
        check("midfill_no_early_ack", ack_seen, a0);
        miss = 2'b00;
        wait_cnt("midfill_ack", 2, a0 + 1);
        wr_req = 1'b0;

        // block at the top of the address space
        @(negedge clk);
        miss_addr[31:16] = 16'hFFF2; miss = 2'b10;
        @(posedge clk); #1; k = cyc;
        push_fill(1, 16'hFFF0, k, WORDS, WORDS);
        wait_cnt("wrap_tag", 0, tag_seen + 1);
        miss = 2'b00;

        // round-robin with both misses held
        @(negedge clk);
        miss_addr_rr = {16'h0700, 16'h0300};
        q_rr.push_back(2'b01); q_rr.push_back(2'b10);
        q_rr.push_back(2'b01); q_rr.push_back(2'b10);
        miss_rr = 2'b11;
        wait_cnt("rr_four_fills", 3, rr_tags + 4);
        miss_rr = 2'b00;
        repeat (4) @(negedge clk);

        // reset after three words of a fill
        @(negedge clk);
        miss_addr[15:0] = 16'h3004; miss = 2'b01;
        @(posedge clk); #1; k = cyc; f0 = fill_seen;
        push_fill(0, 16'h3000, k, 7, 3);
        wait_cnt("rst_three_words", 1, f0 + 3);
        rst = 1'b0; miss = 2'b00;
        #1;
        check("rst_busy_now", {31'h0, busy}, 32'h0);
        check("rst_mem_enable_now", {31'h0, mem_enable}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        #3;
        check("stray_valid_ignored", fill_seen, f0 + 3);

        repeat (3) @(negedge clk);
        check("q_mem_drained", q_mem.size(), 32'h0);
        check("q_fill_drained", q_fill.size(), 32'h0);
        check("q_rr_drained", q_rr.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
